io_entrada_decimal: RTL

Decimal keypad-entry front end for the processor's `IN` instruction. It synchronizes and debounces the board push-button, then samples the 4-bit switch bank on each debounced press. Presses build a value of up to three decimal digits, and a commit press returns that value as a 32-bit word to the CPU through a level request / valid handshake. It sits upstream of the CPU's I/O path and of the three seven-segment decoders: it feeds the data word, the halt/busy condition and the BCD digits shown while the user types.

---
 rtl/io_entrada_decimal.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/io_entrada_decimal.sv
// Decimal keypad-entry front end for the CPU IN instruction.
// The board button is synchronized, debounced and edge-detected into a
// one-cycle press. Each press samples the switch bank: values 0..9 append
// a decimal digit (at most three), values 10..15 commit the typed value.
//
// CPU handshake: req is a level held by the CPU while an IN is pending.
// valid rises on the commit edge and stays high while req stays high;
// the edge after req falls clears valid. If req falls before a commit,
// the session is abandoned and valid never rises.
module io_entrada_decimal #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        botaoPlaca,
   input  logic [3:0]  entradaDeDadosIO,
   input  logic        req,
   output logic [31:0] dado,
   output logic        valid,
   output logic        busy,
   output logic        ledin,
   output logic [3:0]  digCentena,
   output logic [3:0]  digDezena,
   output logic [3:0]  digUnidade,
   output logic [1:0]  estadoDebug
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } estado_t;

   logic             botaoMeta;
   logic             botaoSync;
   logic [3:0]       swMeta;
   logic [3:0]       swSync;
   logic             stable;
   logic             stableQ;
   logic [CNT_W-1:0] contador;
   logic             press;
   estado_t          estado;
   logic [9:0]       acc;
   logic [1:0]       n;
   logic [9:0]       accNext;

   // Two-flop synchronizers; the button is inverted so 1 means pressed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         botaoMeta <= 1'b0;
         botaoSync <= 1'b0;
         swMeta    <= 4'd0;
         swSync    <= 4'd0;
      end else begin
         botaoMeta <= ~botaoPlaca;
         botaoSync <= botaoMeta;
         swMeta    <= entradaDeDadosIO;
         swSync    <= swMeta;
      end
   end

   // Debounce: accept a new level only after it differs from stable for
   // DEBOUNCE_CYCLES consecutive samples; any return to stable restarts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable   <= 1'b0;
         contador <= '0;
      end else if (botaoSync == stable) begin
         contador <= '0;
      end else if (contador == CNT_LAST) begin
         stable   <= botaoSync;
         contador <= '0;
      end else begin
         contador <= contador + 1'b1;
      end
   end

   // One-cycle press pulse on each rising edge of the debounced level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stableQ <= 1'b0;
         press   <= 1'b0;
      end else begin
         stableQ <= stable;
         press   <= stable & ~stableQ;
      end
   end

   // acc*10 + digit never exceeds 999, so 10 bits is always enough.
   assign accNext = (acc * 10'd10) + {6'd0, swSync};

   // Entry session FSM with registered data, valid and digit outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= IDLE;
         acc        <= 10'd0;
         n          <= 2'd0;
         dado       <= 32'd0;
         valid      <= 1'b0;
         digCentena <= 4'd0;
         digDezena  <= 4'd0;
         digUnidade <= 4'd0;
      end else begin
         case (estado)
            IDLE: begin
               if (req) begin
                  estado     <= COLLECT;
                  acc        <= 10'd0;
                  n          <= 2'd0;
                  digCentena <= 4'd0;
                  digDezena  <= 4'd0;
                  digUnidade <= 4'd0;
               end
            end
            COLLECT: begin
               // Abort outranks a press landing on the same cycle.
               if (!req) begin
                  estado <= IDLE;
               end else if (press) begin
                  if (swSync >= 4'd10) begin
                     dado   <= {22'd0, acc};
                     valid  <= 1'b1;
                     estado <= DONE;
                  end else if (n < 2'd3) begin
                     acc        <= accNext;
                     n          <= n + 2'd1;
                     digCentena <= digDezena;
                     digDezena  <= digUnidade;
                     digUnidade <= swSync;
                  end
               end
            end
            DONE: begin
               if (!req) begin
                  estado <= IDLE;
                  valid  <= 1'b0;
               end
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

   assign busy        = (estado == COLLECT);
   assign ledin       = busy;
   assign estadoDebug = estado;

endmodule
